stall_ctrl: RTL

Pipeline hazard and shared-bus controller for the five-stage THCO-MIPS core. Combines the stall requests from ID (load-use) and EX (multi-cycle op) with ownership of the single instruction/data memory bus shared by IF and MEM, and drives the `StallRegBus` vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. Also sequences IF/ID flushes so that a flush arriving while IF/ID is held is not lost.

---
 rtl/stall_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline hazard and shared-bus controller for the five-stage THCO-MIPS core.
// Merges ID/EX stall requests with IF/MEM ownership of the single memory bus into the
// StallRegBus vector, and sequences IF/ID flushes so one arriving under a hold is kept.
// Optional feature: define STALL_CTRL_PERF_EN to build the stalled-cycle counter; when it
// is undefined stall_cnt_o is tied to zero and perf_clr_i is ignored.
module stall_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        mem_req_i,
  input  logic        bus_ready_i,
  input  logic        flush_i,
  input  logic        perf_clr_i,
  output logic [5:0]  stall_o,
  output logic        bus_owner_o,
  output logic        flush_o,
  output logic        bus_err_o,
  output logic [15:0] stall_cnt_o
);

  // Bus FSM encoding
  localparam logic StIdle = 1'b0;
  localparam logic StWait = 1'b1;

  // Stall masks; each is a contiguous prefix so their OR stays a prefix
  localparam logic [5:0] MaskIf  = 6'b000011;
  localparam logic [5:0] MaskId  = 6'b000111;
  localparam logic [5:0] MaskEx  = 6'b001111;
  localparam logic [5:0] MaskMem = 6'b011111;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [5:0]       bus_mask;
  logic             bus_owner;
  logic             bus_err;
  logic [5:0]       stall_raw;
  logic             flush_raw;

  // Bus ownership FSM: decides owner, bus-related stall mask and timeout release
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_mask  = 6'b000000;
    bus_owner = 1'b0;
    bus_err   = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_req_i) begin
          bus_owner = 1'b1;
          if (bus_ready_i) begin
            bus_mask = MaskIf;
          end else begin
            bus_mask = MaskMem;
            state_d  = StWait;
            cnt_d    = CNT_W'(1);
          end
        end
      end
      StWait: begin
        // MEM keeps the bus until the access completes or times out
        bus_owner = 1'b1;
        if (bus_ready_i) begin
          bus_mask = MaskIf;
          state_d  = StIdle;
          cnt_d    = '0;
        end else if (cnt_q >= TimeoutCnt) begin
          bus_mask = MaskIf;
          bus_err  = 1'b1;
          state_d  = StIdle;
          cnt_d    = '0;
        end else begin
          bus_mask = MaskMem;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Merge stall sources and resolve flushes against the IF/ID hold
  always_comb begin
    stall_raw = bus_mask;
    if (stallreq_id_i) stall_raw = stall_raw | MaskId;
    if (stallreq_ex_i) stall_raw = stall_raw | MaskEx;
    flush_raw = (flush_i | pend_q) & ~stall_raw[1];
    pend_d    = pend_q;
    if (flush_raw) begin
      pend_d = 1'b0;
    end else if (flush_i && stall_raw[1] && !stall_raw[2]) begin
      // IF/ID held but ID is live: remember the flush for the next free cycle.
      // With ID held the branch re-issues, so the request is dropped.
      pend_d = 1'b1;
    end
  end

  // Outputs are forced quiet while reset is asserted
  always_comb begin
    stall_o     = rst ? stall_raw : 6'b000000;
    bus_owner_o = rst & bus_owner;
    flush_o     = rst & flush_raw;
    bus_err_o   = rst & bus_err;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

`ifdef STALL_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating stalled-cycle counter; clear takes priority over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr_i) begin
      stall_cnt_d = 16'h0000;
    end else if (stall_raw[0] && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;
  assign stall_cnt_o     = 16'h0000;
`endif

endmodule
